// File: rtl/munoc_ahb_master_request_slice.sv
// AHB-lite master-side request slice: registers one upstream transfer,
// reissues it downstream as SINGLE/NONSEQ and returns data/response.
module munoc_ahb_master_request_slice #(
   parameter int BW_PLATFORM_ADDR = 32,
   parameter int BW_NODE_DATA     = 32
)(
   input  logic                        clk,
   input  logic                        rstnn,
   input  logic [BW_PLATFORM_ADDR-1:0] rhaddr,
   input  logic [2:0]                  rhburst,
   input  logic                        rhmasterlock,
   input  logic [3:0]                  rhprot,
   input  logic [2:0]                  rhsize,
   input  logic [1:0]                  rhtrans,
   input  logic                        rhwrite,
   input  logic [BW_NODE_DATA-1:0]     rhwdata,
   output logic [BW_NODE_DATA-1:0]     rhrdata,
   output logic                        rhready,
   output logic                        rhresp,
   output logic [BW_PLATFORM_ADDR-1:0] shaddr,
   output logic [2:0]                  shburst,
   output logic                        shmasterlock,
   output logic [3:0]                  shprot,
   output logic [2:0]                  shsize,
   output logic [1:0]                  shtrans,
   output logic                        shwrite,
   output logic [BW_NODE_DATA-1:0]     shwdata,
   input  logic [BW_NODE_DATA-1:0]     shrdata,
   input  logic                        shready,
   input  logic                        shresp,
   output logic                        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_OKAY,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t state_q, state_d;

   logic [BW_PLATFORM_ADDR-1:0] addr_q, addr_d;
   logic                        write_q, write_d;
   logic [2:0]                  size_q, size_d;
   logic [3:0]                  prot_q, prot_d;
   logic                        lock_q, lock_d;
   logic [BW_NODE_DATA-1:0]     wdata_q, wdata_d;
   logic [BW_NODE_DATA-1:0]     rdata_q, rdata_d;

   logic capture;
   logic unused_inputs;

   // Burst type and the SEQ/NONSEQ distinction are irrelevant here.
   assign unused_inputs = ^{rhburst, rhtrans[0]};

   // Only ready states can accept a new NONSEQ/SEQ address phase.
   assign capture = rhready & rhtrans[1];

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         prot_q  <= '0;
         lock_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
         prot_q  <= prot_d;
         lock_q  <= lock_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_OKAY, S_ERR2: begin
            state_d = capture ? S_ADDR : S_IDLE;
         end
         S_ADDR: begin
            if (shready) state_d = S_DATA;
         end
         S_DATA: begin
            if (shready) state_d = shresp ? S_ERR1 : S_OKAY;
         end
         S_ERR1: begin
            state_d = S_ERR2;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Request capture, write data at ADDR->DATA, read data on OKAY.
   always_comb begin
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      prot_d  = prot_q;
      lock_d  = lock_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (capture) begin
         addr_d  = rhaddr;
         write_d = rhwrite;
         size_d  = rhsize;
         prot_d  = rhprot;
         lock_d  = rhmasterlock;
      end
      if (state_q == S_ADDR && shready) begin
         wdata_d = rhwdata;
      end
      if (state_q == S_DATA && shready && !shresp && !write_q) begin
         rdata_d = shrdata;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      rhready      = 1'b1;
      rhresp       = 1'b0;
      rhrdata      = rdata_q;
      shtrans      = 2'b00;
      shburst      = 3'b000;
      shaddr       = addr_q;
      shwrite      = write_q;
      shsize       = size_q;
      shprot       = prot_q;
      shmasterlock = lock_q;
      shwdata      = wdata_q;
      busy         = (state_q != S_IDLE);
      unique case (state_q)
         S_ADDR: begin
            rhready = 1'b0;
            shtrans = 2'b10;
         end
         S_DATA: begin
            rhready = 1'b0;
         end
         S_ERR1: begin
            rhready = 1'b0;
            rhresp  = 1'b1;
         end
         S_ERR2: begin
            rhresp = 1'b1;
         end
         default: begin
            rhready = 1'b1;
         end
      endcase
   end

endmodule
